// File: rtl/lshift_seq_unit_pkg.sv
// Shared definitions for the iterative left-shift/rotate engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lshift_seq_unit_pkg;

  // Controller states: waiting, shifting one bit per cycle, result presented.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Operation select carried on the mode port.
  localparam logic MODE_SHL = 1'b0;  // logical left shift, zero fill
  localparam logic MODE_ROL = 1'b1;  // rotate left, MSB re-enters at LSB

endpackage

// File: rtl/lshift_step.sv
// Single-step left shift cell: moves din up one position and inserts fill.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   din     [N-1:0]  word to shift
//   fill             bit inserted at the LSB
//   dout    [N-1:0]  shifted word
//   msb_out          bit pushed out of the MSB
module lshift_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  input  logic         fill,
  output logic [N-1:0] dout,
  output logic         msb_out
);

  assign dout    = {din[N-2:0], fill};
  assign msb_out = din[N-1];

endmodule

// File: rtl/lshift_seq_unit.sv
// Multi-cycle SHL/ROL engine: shifts operand A left by shamt, one bit per clock.
// Latency: done is high in the cycle after edge k+shamt for a start accepted at edge k.
// Backpressure: start is ignored while busy; no queuing, operands are not resampled.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, mode, A, shamt request, op select (0 shl / 1 rol), operand, amount
//   busy, done            shifting in progress / one-cycle result strobe
//   C, carry_out, ovf     result, last bit shifted out, sticky lost-bit flag
module lshift_seq_unit
  import lshift_seq_unit_pkg::*;
#(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  C,
  output logic          carry_out,
  output logic          ovf
);

  state_t        state, state_nxt;
  logic [SW-1:0] cnt;
  logic          mode_q;
  logic          start_acc;
  logic          fill;
  logic [N-1:0]  step_dat;
  logic          step_msb;

  // A request is only honoured when not mid-shift; IDLE and DONE both accept.
  assign start_acc = start && (state != ST_SHIFT);

  // Rotate feeds the outgoing MSB back in at the bottom.
  assign fill = (mode_q == MODE_ROL) ? C[N-1] : 1'b0;

  lshift_step #(.N(N)) u_step (
    .din     (C),
    .fill    (fill),
    .dout    (step_dat),
    .msb_out (step_msb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // cnt counts remaining shifts; the one at cnt==1 is the last.
        if (cnt == SW'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, per-cycle shift, flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      C         <= '0;
      cnt       <= '0;
      mode_q    <= MODE_SHL;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else if (start_acc) begin
      C         <= A;
      cnt       <= shamt;
      mode_q    <= mode;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == ST_SHIFT) begin
      C         <= step_dat;
      cnt       <= cnt - SW'(1);
      carry_out <= step_msb;
      // Only a logical shift loses bits; rotate keeps them in the word.
      ovf       <= ovf | (step_msb & (mode_q == MODE_SHL));
    end
  end

endmodule

// File: tb/tb_lshift_seq_unit.sv
module tb_lshift_seq_unit;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [N-1:0] A;
  logic [2:0]   shamt;
  logic         busy;
  logic         done;
  logic [N-1:0] C;
  logic         carry_out;
  logic         ovf;

  int nchk;
  int npass;
  logic [9:0] last_exp;  // {ovf, carry, C} of the most recent completed op

  lshift_seq_unit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .A         (A),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .C         (C),
    .carry_out (carry_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of shifting a left by s as a whole-word operation: {ovf, carry, C}.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input int s, input logic m);
    logic [15:0] w;
    logic [7:0]  res;
    logic        cy;
    logic        of;
    w   = {8'h00, a} << s;
    res = m ? (w[7:0] | w[15:8]) : w[7:0];
    cy  = (s == 0) ? 1'b0 : a[8 - s];
    of  = m ? 1'b0 : (|w[15:8]);
    return {of, cy, res};
  endfunction

  // Issue one operation and follow it to its done cycle. Returns with done high.
  task automatic run_op(input logic [7:0] a, input logic [2:0] s, input logic m, input bit repulse);
    logic [9:0] exp;
    int cyc;
    exp   = ref_op(a, int'(s), m);
    A     = a;
    shamt = s;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble operand inputs: the captured copy must be used.
    A     = 8'($urandom);
    shamt = 3'($urandom);
    mode  = 1'($urandom);
    cyc   = 0;
    while (!done && cyc < 20) begin
      chk("busy_in_flight", 32'(busy), 32'd1);
      if (repulse && cyc == 1) begin
        start = 1'b1;
        A     = 8'h00;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'(s));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("result_C", 32'(C), 32'(exp[7:0]));
    chk("carry_out", 32'(carry_out), 32'(exp[8]));
    chk("ovf", 32'(ovf), 32'(exp[9]));
    last_exp = exp;
  endtask

  // Idle cycles after a result: done drops, result and flags hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("done_drops", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("hold_result", 32'({ovf, carry_out, C}), 32'(last_exp));
    end
  endtask

  initial begin
    nchk     = 0;
    npass    = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    A        = '0;
    shamt    = '0;
    tick();
    tick();
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({carry_out, ovf}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(8'hB4, 3'd3, 1'b0, 1'b0);
    chk("dir1_C", 32'(C), 32'hA0);
    idle(1);
    run_op(8'hB4, 3'd3, 1'b1, 1'b0);
    chk("dir2_C", 32'(C), 32'hA5);
    idle(1);
    run_op(8'h0F, 3'd4, 1'b0, 1'b0);
    idle(1);
    run_op(8'h01, 3'd7, 1'b0, 1'b0);
    chk("dir3_C", 32'(C), 32'h80);
    idle(1);
    run_op(8'h5A, 3'd0, 1'b0, 1'b0);
    chk("dir4_C", 32'(C), 32'h5A);
    idle(2);
    run_op(8'hFF, 3'd5, 1'b0, 1'b1);
    chk("dir5_C", 32'(C), 32'hE0);
    chk("dir5_ovf", 32'(ovf), 32'd1);
    run_op(8'h81, 3'd2, 1'b1, 1'b0);  // back-to-back from DONE
    chk("dir5_b2b_C", 32'(C), 32'h06);
    idle(1);

    // Reset mid-operation aborts without a done pulse.
    A     = 8'hC3;
    shamt = 3'd6;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_C", 32'(C), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'({carry_out, ovf}), 32'd0);
    rst_n    = 1'b1;
    last_exp = '0;
    idle(8);

    // Randomized operations with random ignored re-pulses, back-to-back starts and gaps.
    for (int t = 0; t < 60; t++) begin
      run_op(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        idle($urandom_range(1, 3));
      end
    end
    idle(1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
